// File: rtl/key_sw_input_if.sv
// Load/store bus between the memory stage and the KEY/SW input peripheral.
// The CPU side drives address, qualifiers and store data; the peripheral returns read data.
interface key_sw_input_if;
  logic [31:0] dataAddr;
  logic        isLoad;
  logic        isStore;
  logic [31:0] wrData;
  logic [31:0] rdData;

  modport master (output dataAddr, output isLoad, output isStore, output wrData, input rdData);
  modport slave  (input dataAddr, input isLoad, input isStore, input wrData, output rdData);
endinterface

// File: rtl/key_sw_input.sv
// KEY/SW input peripheral: synchronizers, optional debounce (KEY_SW_DEBOUNCE_EN),
// sticky key-press status (KCTRL) and zero-cycle read data for the KEY, SW and KCTRL addresses.
module key_sw_input #(
  parameter int unsigned KEY_BITS        = 4,
  parameter int unsigned SW_BITS         = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_BITS        = 8,
  parameter logic [31:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [31:0] ADDR_SW         = 32'hF0000014,
  parameter logic [31:0] ADDR_KCTRL      = 32'hF0000110
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_BITS-1:0] KEY,
  input  logic [SW_BITS-1:0]  SW,
  key_sw_input_if.slave       bus,
  output logic                keyPending
);

  localparam int unsigned NBits = KEY_BITS + SW_BITS;

  // Keys occupy the upper bits of the combined vector, switches the lower bits.
  logic [NBits-1:0]    r_sync1, r_sync2, r_db, w_db_d;
  logic [KEY_BITS-1:0] w_rise, r_last, w_last_d;
  logic                r_ready, w_ready_d, r_ovr, w_ovr_d;
  logic                w_ld_key, w_clr_ovr;
  logic [31:0]         w_kctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {~KEY, SW};
      r_sync2 <= r_sync1;
    end
  end

`ifdef KEY_SW_DEBOUNCE_EN
  logic [CNT_BITS-1:0] r_cnt [NBits];
  logic [CNT_BITS-1:0] w_cnt_d [NBits];

  always_comb begin
    for (int i = 0; i < NBits; i++) begin
      w_cnt_d[i] = r_cnt[i];
      w_db_d[i]  = r_db[i];
      if (r_sync2[i] == r_db[i]) begin
        w_cnt_d[i] = '0;
      end else if (r_cnt[i] == CNT_BITS'(DEBOUNCE_CYCLES - 1)) begin
        w_db_d[i]  = r_sync2[i];
        w_cnt_d[i] = '0;
      end else begin
        w_cnt_d[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBits; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBits; i++) r_cnt[i] <= w_cnt_d[i];
    end
  end
`else
  assign w_db_d = r_sync2;
`endif

  assign w_rise    = w_db_d[NBits-1 -: KEY_BITS] & ~r_db[NBits-1 -: KEY_BITS];
  assign w_ld_key  = bus.isLoad && (bus.dataAddr == ADDR_KEY);
  // A simultaneous load takes precedence, so a store only counts when isLoad is low.
  assign w_clr_ovr = bus.isStore && !bus.isLoad && (bus.dataAddr == ADDR_KCTRL) &&
                     !bus.wrData[1];

  always_comb begin
    w_ready_d = r_ready;
    w_ovr_d   = r_ovr;
    w_last_d  = r_last;
    if (|w_rise) begin
      w_ready_d = 1'b1;
      w_last_d  = w_rise;
      if (r_ready && !w_ld_key) w_ovr_d = 1'b1;
      else if (w_clr_ovr)       w_ovr_d = 1'b0;
    end else begin
      if (w_ld_key)  w_ready_d = 1'b0;
      if (w_clr_ovr) w_ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db    <= '0;
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
      r_last  <= '0;
    end else begin
      r_db    <= w_db_d;
      r_ready <= w_ready_d;
      r_ovr   <= w_ovr_d;
      r_last  <= w_last_d;
    end
  end

  always_comb begin
    w_kctrl               = '0;
    w_kctrl[0]            = r_ready;
    w_kctrl[1]            = r_ovr;
    w_kctrl[4 +: KEY_BITS] = r_last;
  end

  always_comb begin
    bus.rdData = '0;
    if (bus.isLoad) begin
      if (bus.dataAddr == ADDR_KEY)        bus.rdData = 32'(r_db[NBits-1 -: KEY_BITS]);
      else if (bus.dataAddr == ADDR_SW)    bus.rdData = 32'(r_db[SW_BITS-1:0]);
      else if (bus.dataAddr == ADDR_KCTRL) bus.rdData = w_kctrl;
    end
  end

  assign keyPending = r_ready;

endmodule
